// File: rtl/rpc_cmd_arbiter.sv
// Round-robin front-end that multiplexes NUM_CH command/data channels onto the
// single RPC DRAM controller port, holding the grant for the whole data burst.
module rpc_cmd_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int DRAM_ALIGN_POS  = 5,
  parameter int DRAM_ADDR_WIDTH = 20,
  parameter int DRAM_WORD_WIDTH = 256,
  parameter int DRAM_MASK_WIDTH = 64,
  parameter int IDX_W           = $clog2(NUM_CH)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_CH-1:0]                     ch_cmd_valid_i,
  output logic [NUM_CH-1:0]                     ch_cmd_ready_o,
  input  logic [NUM_CH-1:0]                     ch_cmd_is_write_i,
  input  logic [NUM_CH*DRAM_ALIGN_POS-1:0]      ch_cmd_len_i,
  input  logic [NUM_CH*DRAM_ADDR_WIDTH-1:0]     ch_cmd_addr_i,
  input  logic [NUM_CH-1:0]                     ch_w_valid_i,
  output logic [NUM_CH-1:0]                     ch_w_ready_o,
  input  logic [NUM_CH*DRAM_WORD_WIDTH-1:0]     ch_w_data_i,
  input  logic [NUM_CH*DRAM_MASK_WIDTH-1:0]     ch_w_mask_i,
  output logic [NUM_CH-1:0]                     ch_r_valid_o,
  input  logic [NUM_CH-1:0]                     ch_r_ready_i,
  output logic [DRAM_WORD_WIDTH-1:0]            ch_r_data_o,
  output logic                                  ch_r_last_o,
  output logic                                  cmd_valid_o,
  input  logic                                  cmd_ready_i,
  output logic                                  cmd_is_write_o,
  output logic [DRAM_ALIGN_POS-1:0]             cmd_len_o,
  output logic [DRAM_ADDR_WIDTH-1:0]            cmd_addr_o,
  output logic                                  w_data_valid_o,
  input  logic                                  w_data_ready_i,
  output logic [DRAM_WORD_WIDTH-1:0]            w_data_o,
  output logic [DRAM_MASK_WIDTH-1:0]            write_mask_o,
  input  logic                                  r_data_valid_i,
  output logic                                  r_data_ready_o,
  input  logic [DRAM_WORD_WIDTH-1:0]            r_data_i,
  input  logic                                  r_data_last_i,
  output logic [IDX_W-1:0]                      grant_idx_o,
  output logic                                  busy_o,
  output logic                                  len_err_o
);

  typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          rr_ptr, ptr_nxt, grant, grant_nxt, winner, grant_inc;
  logic [DRAM_ALIGN_POS-1:0] beat_cnt, cnt_nxt;
  logic [IDX_W:0]            idx;
  logic                      found;
  logic                      last_beat;

  // Search upward from rr_ptr; idx carries one spare bit so the wrap needs no modulo.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (idx >= (IDX_W+1)'(NUM_CH))
        idx = idx - (IDX_W+1)'(NUM_CH);
      if (!found && ch_cmd_valid_i[idx]) begin
        winner = idx[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  assign grant_inc   = (grant == IDX_W'(NUM_CH-1)) ? '0 : grant + 1'b1;
  assign last_beat   = (beat_cnt == '0);
  assign grant_idx_o = grant;
  assign busy_o      = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    cnt_nxt        = beat_cnt;
    ptr_nxt        = rr_ptr;
    ch_cmd_ready_o = '0;
    cmd_valid_o    = 1'b0;
    cmd_is_write_o = 1'b0;
    cmd_len_o      = '0;
    cmd_addr_o     = '0;
    ch_w_ready_o   = '0;
    w_data_valid_o = 1'b0;
    w_data_o       = '0;
    write_mask_o   = '0;
    ch_r_valid_o   = '0;
    r_data_ready_o = 1'b0;
    ch_r_data_o    = '0;
    ch_r_last_o    = 1'b0;
    len_err_o      = 1'b0;
    case (state)
      // Zero-latency pass-through of the winner; gated while reset is held.
      IDLE: begin
        if (!rst_i) begin
          cmd_valid_o            = |ch_cmd_valid_i;
          cmd_is_write_o         = ch_cmd_is_write_i[winner];
          cmd_len_o              = ch_cmd_len_i[winner*DRAM_ALIGN_POS +: DRAM_ALIGN_POS];
          cmd_addr_o             = ch_cmd_addr_i[winner*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
          ch_cmd_ready_o[winner] = cmd_ready_i;
          if (cmd_valid_o && cmd_ready_i) begin
            grant_nxt = winner;
            cnt_nxt   = cmd_len_o;
            state_nxt = cmd_is_write_o ? WBURST : RBURST;
          end
        end
      end
      WBURST: begin
        w_data_valid_o      = ch_w_valid_i[grant];
        w_data_o            = ch_w_data_i[grant*DRAM_WORD_WIDTH +: DRAM_WORD_WIDTH];
        write_mask_o        = ch_w_mask_i[grant*DRAM_MASK_WIDTH +: DRAM_MASK_WIDTH];
        ch_w_ready_o[grant] = w_data_ready_i;
        if (w_data_valid_o && w_data_ready_i) begin
          if (last_beat) begin
            state_nxt = IDLE;
            ptr_nxt   = grant_inc;
          end else begin
            cnt_nxt = beat_cnt - 1'b1;
          end
        end
      end
      // The beat counter, not r_data_last_i, decides when the burst ends.
      RBURST: begin
        ch_r_valid_o[grant] = r_data_valid_i;
        r_data_ready_o      = ch_r_ready_i[grant];
        ch_r_data_o         = r_data_i;
        ch_r_last_o         = last_beat;
        if (r_data_valid_i && ch_r_ready_i[grant]) begin
          len_err_o = (r_data_last_i != last_beat);
          if (last_beat) begin
            state_nxt = IDLE;
            ptr_nxt   = grant_inc;
          end else begin
            cnt_nxt = beat_cnt - 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= ptr_nxt;
      grant    <= grant_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rpc_cmd_arbiter.sv
// Self-checking bench for rpc_cmd_arbiter: directed scenarios plus randomized
// request sets checked against a transaction-level round-robin/burst model.
module tb_rpc_cmd_arbiter;
  localparam int N  = 4;
  localparam int AP = 5;
  localparam int AW = 20;
  localparam int WW = 256;
  localparam int MW = 64;
  localparam int IW = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      ch_cmd_valid_i, ch_cmd_ready_o, ch_cmd_is_write_i;
  logic [N*AP-1:0]   ch_cmd_len_i;
  logic [N*AW-1:0]   ch_cmd_addr_i;
  logic [N-1:0]      ch_w_valid_i, ch_w_ready_o;
  logic [N*WW-1:0]   ch_w_data_i;
  logic [N*MW-1:0]   ch_w_mask_i;
  logic [N-1:0]      ch_r_valid_o, ch_r_ready_i;
  logic [WW-1:0]     ch_r_data_o;
  logic              ch_r_last_o;
  logic              cmd_valid_o, cmd_ready_i, cmd_is_write_o;
  logic [AP-1:0]     cmd_len_o;
  logic [AW-1:0]     cmd_addr_o;
  logic              w_data_valid_o, w_data_ready_i;
  logic [WW-1:0]     w_data_o;
  logic [MW-1:0]     write_mask_o;
  logic              r_data_valid_i, r_data_ready_o;
  logic [WW-1:0]     r_data_i;
  logic              r_data_last_i;
  logic [IW-1:0]     grant_idx_o;
  logic              busy_o, len_err_o;

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: pending command per channel and the round-robin start point.
  int            rr = 0;
  bit            pend [N];
  bit            p_wr [N];
  logic [AP-1:0] p_len [N];
  logic [AW-1:0] p_addr [N];

  rpc_cmd_arbiter #(
    .NUM_CH(N), .DRAM_ALIGN_POS(AP), .DRAM_ADDR_WIDTH(AW),
    .DRAM_WORD_WIDTH(WW), .DRAM_MASK_WIDTH(MW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ch_cmd_valid_i(ch_cmd_valid_i), .ch_cmd_ready_o(ch_cmd_ready_o),
    .ch_cmd_is_write_i(ch_cmd_is_write_i), .ch_cmd_len_i(ch_cmd_len_i),
    .ch_cmd_addr_i(ch_cmd_addr_i),
    .ch_w_valid_i(ch_w_valid_i), .ch_w_ready_o(ch_w_ready_o),
    .ch_w_data_i(ch_w_data_i), .ch_w_mask_i(ch_w_mask_i),
    .ch_r_valid_o(ch_r_valid_o), .ch_r_ready_i(ch_r_ready_i),
    .ch_r_data_o(ch_r_data_o), .ch_r_last_o(ch_r_last_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_is_write_o(cmd_is_write_o), .cmd_len_o(cmd_len_o), .cmd_addr_o(cmd_addr_o),
    .w_data_valid_o(w_data_valid_o), .w_data_ready_i(w_data_ready_i),
    .w_data_o(w_data_o), .write_mask_o(write_mask_o),
    .r_data_valid_i(r_data_valid_i), .r_data_ready_o(r_data_ready_o),
    .r_data_i(r_data_i), .r_data_last_i(r_data_last_i),
    .grant_idx_o(grant_idx_o), .busy_o(busy_o), .len_err_o(len_err_o)
  );

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int rrPick();
    for (int k = 0; k < N; k++)
      if (pend[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic driveCmds();
    for (int c = 0; c < N; c++) begin
      ch_cmd_valid_i[c]    = pend[c];
      ch_cmd_is_write_i[c] = pend[c] ? p_wr[c] : 1'($urandom);
      ch_cmd_len_i[c*AP +: AP] = pend[c] ? p_len[c] : AP'($urandom);
      ch_cmd_addr_i[c*AW +: AW] = pend[c] ? p_addr[c] : AW'($urandom);
    end
  endtask

  task automatic randomizeInputs();
    for (int i = 0; i < N*WW/32; i++) ch_w_data_i[i*32 +: 32] = $urandom;
    for (int i = 0; i < N*MW/32; i++) ch_w_mask_i[i*32 +: 32] = $urandom;
    for (int i = 0; i < WW/32; i++)   r_data_i[i*32 +: 32]    = $urandom;
    ch_w_valid_i   = N'($urandom) | N'($urandom);
    ch_r_ready_i   = N'($urandom);
    w_data_ready_i = 1'($urandom);
    r_data_valid_i = 1'($urandom);
    r_data_last_i  = 1'($urandom);
    cmd_ready_i    = 1'($urandom);
    driveCmds();
  endtask

  task automatic setCmd(input int c, input bit wr, input int len, input logic [AW-1:0] addr);
    pend[c]   = 1'b1;
    p_wr[c]   = wr;
    p_len[c]  = AP'(len);
    p_addr[c] = addr;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    checkOutput("reset_busy", 256'(busy_o), 256'(0));
    checkOutput("reset_grant", 256'(grant_idx_o), 256'(0));
    checkOutput("reset_valids", 256'({cmd_valid_o, ch_cmd_ready_o, w_data_valid_o, ch_w_ready_o,
                                       ch_r_valid_o, r_data_ready_o, len_err_o}), 256'(0));
    checkOutput("reset_data", 256'(w_data_o ^ ch_r_data_o), 256'(0));
    rst_i = 1'b0;
    rr = 0;
  endtask

  // One complete transaction: arbitration of the model's winner, then its burst.
  // err_beat corrupts r_data_last_i on that beat; rst_beat asserts reset before that beat.
  task automatic applyStimulus(input int err_beat, input int rst_beat);
    int w, beats, got, cyc;
    bit done, hs, exp_last;
    w = rrPick();
    if (w < 0) return;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 50) begin
      @(negedge clk_i);
      randomizeInputs();
      if (cyc >= 3) cmd_ready_i = 1'b1;
      #1;
      checkOutput("idle_busy", 256'(busy_o), 256'(0));
      checkOutput("cmd_valid", 256'(cmd_valid_o), 256'(1));
      checkOutput("cmd_ready", 256'(ch_cmd_ready_o), cmd_ready_i ? 256'(N'(1) << w) : 256'(0));
      checkOutput("idle_stray", 256'({ch_w_ready_o, ch_r_valid_o, w_data_valid_o,
                                      r_data_ready_o, len_err_o}), 256'(0));
      if (cmd_ready_i) begin
        checkOutput("cmd_addr", 256'(cmd_addr_o), 256'(p_addr[w]));
        checkOutput("cmd_len", 256'(cmd_len_o), 256'(p_len[w]));
        checkOutput("cmd_is_write", 256'(cmd_is_write_o), 256'(p_wr[w]));
        done = 1'b1;
      end
      @(posedge clk_i);
      cyc++;
    end
    checkOutput("cmd_handshake", 256'(done), 256'(1));
    if (!done) return;
    pend[w] = 1'b0;
    beats   = int'(p_len[w]) + 1;
    got     = 0;
    cyc     = 0;
    while (got < beats && cyc < 1000) begin
      @(negedge clk_i);
      randomizeInputs();
      exp_last      = (got == beats - 1);
      r_data_last_i = exp_last ^ (got == err_beat);
      if (got == rst_beat) begin
        rst_i          = 1'b1;
        ch_w_valid_i   = '1;
        w_data_ready_i = 1'b1;
      end
      #1;
      if (rst_i) begin
        checkOutput("abort_busy", 256'(busy_o), 256'(0));
        checkOutput("abort_grant", 256'(grant_idx_o), 256'(0));
        checkOutput("abort_valids", 256'({cmd_valid_o, ch_cmd_ready_o, w_data_valid_o, ch_w_ready_o,
                                          ch_r_valid_o, r_data_ready_o, len_err_o}), 256'(0));
        checkOutput("abort_wdata", 256'(w_data_o), 256'(0));
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        rr    = 0;
        return;
      end
      checkOutput("burst_busy", 256'(busy_o), 256'(1));
      checkOutput("burst_grant", 256'(grant_idx_o), 256'(w));
      checkOutput("burst_no_cmd", 256'({cmd_valid_o, ch_cmd_ready_o}), 256'(0));
      if (p_wr[w]) begin
        hs = ch_w_valid_i[w] && w_data_ready_i;
        checkOutput("w_valid", 256'(w_data_valid_o), 256'(ch_w_valid_i[w]));
        checkOutput("w_ready", 256'(ch_w_ready_o), w_data_ready_i ? 256'(N'(1) << w) : 256'(0));
        checkOutput("w_stray_r", 256'({ch_r_valid_o, r_data_ready_o, len_err_o}), 256'(0));
        if (hs) begin
          checkOutput("w_data", 256'(w_data_o), 256'(ch_w_data_i[w*WW +: WW]));
          checkOutput("w_mask", 256'(write_mask_o), 256'(ch_w_mask_i[w*MW +: MW]));
        end
      end else begin
        hs = r_data_valid_i && ch_r_ready_i[w];
        checkOutput("r_valid", 256'(ch_r_valid_o), r_data_valid_i ? 256'(N'(1) << w) : 256'(0));
        checkOutput("r_ready", 256'(r_data_ready_o), 256'(ch_r_ready_i[w]));
        checkOutput("r_data", 256'(ch_r_data_o), 256'(r_data_i));
        checkOutput("r_last", 256'(ch_r_last_o), 256'(exp_last));
        checkOutput("len_err", 256'(len_err_o), 256'(hs && (r_data_last_i != exp_last)));
        checkOutput("r_stray_w", 256'({ch_w_ready_o, w_data_valid_o}), 256'(0));
      end
      if (hs) got++;
      @(posedge clk_i);
      cyc++;
    end
    checkOutput("burst_beats", 256'(got), 256'(beats));
    rr = (w + 1) % N;
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w, e;
    for (int c = 0; c < N; c++) pend[c] = 1'b0;
    ch_cmd_valid_i = '0; ch_cmd_is_write_i = '0; ch_cmd_len_i = '0; ch_cmd_addr_i = '0;
    ch_w_valid_i = '0; ch_w_data_i = '0; ch_w_mask_i = '0; ch_r_ready_i = '0;
    cmd_ready_i = 1'b0; w_data_ready_i = 1'b0; r_data_valid_i = 1'b0;
    r_data_i = '0; r_data_last_i = 1'b0;
    doReset();

    // Single channel 2 write, len 3; pointer should then sit at 3.
    setCmd(2, 1'b1, 3, 20'h00100);
    applyStimulus(-1, -1);

    // All four channels read len 0 after reset: order 0,1,2,3 then 0 again.
    doReset();
    for (int c = 0; c < N; c++) setCmd(c, 1'b0, 0, AW'($urandom));
    for (int k = 0; k < N; k++) applyStimulus(-1, -1);
    setCmd(0, 1'b0, 0, 20'h0ABCD);
    applyStimulus(-1, -1);

    // Eight-beat write with random gaps on both sides.
    setCmd(1, 1'b1, 7, 20'h12345);
    applyStimulus(-1, -1);

    // Read len 3 with r_data_last_i wrongly raised on beat 2.
    setCmd(0, 1'b0, 3, 20'h00F00);
    applyStimulus(1, -1);

    // Reset on beat 3 of a len 7 write, then a lone channel 1 request.
    setCmd(3, 1'b1, 7, 20'h55555);
    applyStimulus(-1, 2);
    setCmd(1, 1'b0, 2, 20'h00042);
    applyStimulus(-1, -1);

    // Channel 0 waits through channel 2's burst (pointer is at 2).
    setCmd(2, 1'b1, 4, 20'h00200);
    setCmd(0, 1'b0, 1, 20'h00300);
    applyStimulus(-1, -1);
    applyStimulus(-1, -1);

    // Random request sets drained in round-robin order.
    for (int r = 0; r < 30; r++) begin
      w = int'($urandom_range(1, (1 << N) - 1));
      for (int c = 0; c < N; c++)
        if (w[c]) setCmd(c, 1'($urandom), int'($urandom_range(0, 15)), AW'($urandom));
      while (rrPick() >= 0) begin
        e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(p_len[rrPick()]))) : -1;
        applyStimulus(e, -1);
      end
    end

    @(negedge clk_i);
    ch_cmd_valid_i = '0;
    #1;
    checkOutput("final_idle", 256'({busy_o, cmd_valid_o}), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rpc_cmd_arbiter.md
Name: rpc_cmd_arbiter

Overview:
- N-channel front-end for the RPC DRAM controller command and data path.
- Arbitrates NUM_CH independent AXI-side command/data channels onto the single controller command port (cmd valid/ready, is_write, len, addr) and the phy data port.
- Holds the grant for the full data burst of the accepted command.
- Successor to the single-channel connection: adds channel count, fair round-robin arbitration, burst tracking and read-last checking.

Parameters:
- NUM_CH, 4, number of upstream channels (>=2).
- DRAM_ALIGN_POS, 5, width of len field; burst length = len+1 beats.
- DRAM_ADDR_WIDTH, 20, bank+row+column address width.
- DRAM_WORD_WIDTH, 256, data beat width.
- DRAM_MASK_WIDTH, 64, write mask width.
- IDX_W, $clog2(NUM_CH), derived channel index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- ch_cmd_valid_i  in  NUM_CH  per-channel command valid.
- ch_cmd_ready_o  out  NUM_CH  per-channel command ready.
- ch_cmd_is_write_i  in  NUM_CH  1 = write.
- ch_cmd_len_i  in  NUM_CH*DRAM_ALIGN_POS  beats-1, channel c at slice c.
- ch_cmd_addr_i  in  NUM_CH*DRAM_ADDR_WIDTH  word address.
- ch_w_valid_i / ch_w_ready_o  in/out  NUM_CH  write data handshake.
- ch_w_data_i  in  NUM_CH*DRAM_WORD_WIDTH  write data.
- ch_w_mask_i  in  NUM_CH*DRAM_MASK_WIDTH  write mask.
- ch_r_valid_o / ch_r_ready_i  out/in  NUM_CH  read data handshake.
- ch_r_data_o  out  DRAM_WORD_WIDTH  read data, broadcast to all channels.
- ch_r_last_o  out  1  read last, broadcast.
- cmd_valid_o / cmd_ready_i  out/in  1  downstream command handshake.
- cmd_is_write_o, cmd_len_o, cmd_addr_o  out  1/DRAM_ALIGN_POS/DRAM_ADDR_WIDTH  granted command.
- w_data_valid_o / w_data_ready_i  out/in  1  downstream write handshake.
- w_data_o, write_mask_o  out  DRAM_WORD_WIDTH/DRAM_MASK_WIDTH.
- r_data_valid_i / r_data_ready_o  in/out  1  downstream read handshake.
- r_data_i, r_data_last_i  in  DRAM_WORD_WIDTH/1.
- grant_idx_o  out  IDX_W  current or last granted channel.
- busy_o  out  1  high in any state other than IDLE.
- len_err_o  out  1  one-cycle pulse on read-last mismatch.

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0.
  - All valid/ready outputs 0, busy_o=0, len_err_o=0.
  - Data outputs 0.
- Reset asserted mid-burst aborts immediately to the reset values; no further beats are forwarded.
- States: IDLE, WBURST, RBURST.
- IDLE arbitration:
  - Combinational round-robin over ch_cmd_valid_i, searching from rr_ptr upward with wrap at NUM_CH-1 -> 0. Winner w.
  - cmd_valid_o = |ch_cmd_valid_i; cmd_* fields are taken from w.
  - ch_cmd_ready_o[w] = cmd_ready_i; all other ready bits 0.
  - Zero-latency pass-through; no command register.
  - Winner must stay stable while cmd_valid_o is high, because rr_ptr and the valids do not change until the handshake. Upstream must hold valid (AXI rule).
- On cmd handshake:
  - grant <= w, beat_cnt <= len.
  - Next state WBURST if is_write, else RBURST.
  - rr_ptr unchanged until burst end.
- WBURST:
  - w_data_valid_o = ch_w_valid_i[grant]; data and mask from grant.
  - ch_w_ready_o[grant] = w_data_ready_i; other channels' w_ready stay 0.
  - Each handshake with beat_cnt>0 decrements beat_cnt.
  - Handshake with beat_cnt==0: state <= IDLE, rr_ptr <= grant+1 (mod NUM_CH).
- RBURST:
  - ch_r_valid_o[grant] = r_data_valid_i; r_data_ready_o = ch_r_ready_i[grant].
  - ch_r_data_o = r_data_i, ch_r_last_o = (beat_cnt==0).
  - Each handshake decrements beat_cnt.
  - Handshake with beat_cnt==0: state <= IDLE, rr_ptr <= grant+1.
  - On any handshake, len_err_o pulses for 1 cycle when r_data_last_i != (beat_cnt==0). The counter stays authoritative for the exit.
- No command is accepted while busy_o=1; cmd_valid_o=0 outside IDLE.
- The next grant may handshake in the cycle after the last beat (1 idle cycle minimum between bursts).
- Stray downstream activity: r_data_valid_i in IDLE/WBURST and w_data_ready_i in IDLE/RBURST are ignored; all upstream valid/ready bits stay 0.
- len=0 means a single-beat burst.

Test Plan:
- Reset, single channel 2 requests write len=3 addr=0x00100 -> cmd_valid_o=1 same cycle, cmd_addr_o=0x00100; exactly 4 write beats forwarded; busy_o falls after beat 4; rr_ptr=3.
- All 4 channels valid simultaneously with reads len=0, ch_r_ready_i all 1 -> grants in order 0,1,2,3,0; each channel receives exactly 1 beat with ch_r_last_o=1.
- Write burst len=7 with w_data_ready_i toggling 1/0 and ch_w_valid_i gaps -> 8 beats in order; data and mask match source; no beats delivered to other channels.
- Read len=3 with r_data_last_i asserted on beat 2 -> len_err_o pulses once on beat 2; burst still ends after beat 4.
- rst_i asserted on beat 3 of a len=7 write -> next cycle all valid/ready outputs 0, state IDLE; a new request on channel 1 is granted (rr_ptr=0, only ch1 valid).
- Channel 0 holds cmd_valid during another channel's burst -> ch_cmd_ready_o[0] stays 0 until IDLE, then ch0 is granted.
